// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg: shared types and helpers for the audio mixing stage.
//   mix_state_e : fade/switch FSM state
//   MIX_W       : width of the raw per-channel sum
//   OUT_W       : width of the output sample
//   mix_sum()   : raw 10-bit sum for one channel in the selected mode
package audio_mix_pkg;

    localparam int unsigned MIX_W = 10;
    localparam int unsigned OUT_W = 16;

    typedef enum logic [1:0] {
        StRun,
        StFadeOut,
        StSwitch,
        StFadeIn
    } mix_state_e;

    // psg_main is channel A for the left side, channel C for the right side.
    // Worst case 0x1FE + 0xFF + 0xE0 stays below 2^10, so no saturation is needed.
    function automatic logic [MIX_W-1:0] mix_sum(
        input logic       covox_mode,
        input logic [7:0] cov_byte,
        input logic [7:0] psg_main,
        input logic [7:0] psg_b,
        input logic [2:0] spk,
        input logic       psg_active
    );
        logic [MIX_W-1:0] spk_term;
        spk_term = {2'b00, spk, 5'b00000};
        if (covox_mode) begin
            return {1'b0, cov_byte, 1'b0} + spk_term;
        end else if (psg_active) begin
            return {1'b0, psg_main, 1'b0} + {2'b00, psg_b} + spk_term;
        end else begin
            return {spk, 7'b0000000};
        end
    endfunction

endpackage

// File: rtl/audio_dcblock.sv
// audio_dcblock: single-channel first-order DC blocker used by audio_mix when
// AUDIO_MIX_DCBLOCK_EN is defined.
//   clk_sys : system clock
//   reset   : synchronous active-high reset, clears filter state
//   clr     : synchronous clear of filter state (mode switch)
//   en      : advance filter state this cycle (stage-2 sample cycles)
//   din     : unsigned offset-binary input sample
//   dout    : unsigned offset-binary filtered sample (combinational)
module audio_dcblock
    import audio_mix_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] dout
);

    localparam logic signed [17:0] SatMax = 18'sd32767;
    localparam logic signed [17:0] SatMin = -18'sd32768;

    logic signed [17:0] x;
    logic signed [17:0] y;
    logic signed [17:0] x_prev_q;
    logic signed [17:0] y_prev_q;

    assign x = $signed({2'b00, din}) - 18'sd32768;
    assign y = x - x_prev_q + y_prev_q - (y_prev_q >>> 8);

    // Saturate to signed 16 bits, then flip the MSB to return to offset binary.
    always_comb begin
        dout = 16'h0000;
        if (y > SatMax) begin
            dout = 16'hFFFF;
        end else if (y < SatMin) begin
            dout = 16'h0000;
        end else begin
            dout = y[15:0] ^ 16'h8000;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || clr) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
        end else if (en) begin
            x_prev_q <= x;
            y_prev_q <= y;
        end
    end

endmodule

// File: rtl/audio_mix.sv
// audio_mix: sample-rate mixer for PSG, speaker and Covox sources with click-free
// fade-out / fade-in on every PSG <-> Covox mode change.
// Optional feature: define AUDIO_MIX_DCBLOCK_EN to add a per-channel DC blocker.
//   clk_sys      : system clock
//   reset        : synchronous active-high reset
//   ce           : one-cycle sample tick
//   covox_enable : requested mode (1 = Covox, 0 = PSG)
//   covox_data   : Covox latch, [7:0] left, [15:8] right
//   spk          : speaker bits
//   psg_a/b/c    : PSG channels, unsigned
//   psg_active   : PSG has at least one active channel
//   left/right   : unsigned offset-binary samples
//   valid        : one-cycle pulse when left/right update (2 cycles after ce)
//   mode         : mode currently being played
//   fading       : high while a fade is in progress
module audio_mix
    import audio_mix_pkg::*;
#(
    parameter int unsigned RAMP_SHIFT = 4,
    parameter int unsigned RAMP_DIV   = 64
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce,
    input  logic             covox_enable,
    input  logic [15:0]      covox_data,
    input  logic [2:0]       spk,
    input  logic [7:0]       psg_a,
    input  logic [7:0]       psg_b,
    input  logic [7:0]       psg_c,
    input  logic             psg_active,
    output logic [OUT_W-1:0] left,
    output logic [OUT_W-1:0] right,
    output logic             valid,
    output logic             mode,
    output logic             fading
);

    localparam int unsigned GAIN_W = RAMP_SHIFT + 1;
    localparam int unsigned PROD_W = OUT_W + RAMP_SHIFT + 1;
    localparam logic [GAIN_W-1:0] GainUnity = GAIN_W'(1) << RAMP_SHIFT;
    localparam logic [GAIN_W-1:0] GainOne   = GAIN_W'(1);
    localparam logic [7:0]        DivLast   = 8'(RAMP_DIV - 1);

    mix_state_e        state_q;
    logic [GAIN_W-1:0] gain_q;
    logic [7:0]        tick_q;
    logic              mode_q;
    logic              fading_q;
    logic              tick_step;

    assign tick_step = (tick_q == DivLast);

    // Fade FSM; everything advances only on the sample tick.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= StRun;
            gain_q   <= GainUnity;
            tick_q   <= 8'd0;
            mode_q   <= covox_enable;
            fading_q <= 1'b0;
        end else if (ce) begin
            case (state_q)
                StRun: begin
                    if (covox_enable != mode_q) begin
                        state_q  <= StFadeOut;
                        fading_q <= 1'b1;
                        tick_q   <= 8'd0;
                    end
                end
                StFadeOut: begin
                    if (tick_step) begin
                        tick_q <= 8'd0;
                        if (gain_q <= GainOne) begin
                            gain_q  <= '0;
                            state_q <= StSwitch;
                        end else begin
                            gain_q <= gain_q - GainOne;
                        end
                    end else begin
                        tick_q <= tick_q + 8'd1;
                    end
                end
                StSwitch: begin
                    // If the request was withdrawn this keeps the old mode.
                    mode_q  <= covox_enable;
                    state_q <= StFadeIn;
                    tick_q  <= 8'd0;
                end
                StFadeIn: begin
                    if (covox_enable != mode_q) begin
                        // Reverse from the current gain, no jump.
                        state_q <= StFadeOut;
                        tick_q  <= 8'd0;
                    end else if (tick_step) begin
                        tick_q <= 8'd0;
                        if (gain_q >= GainUnity - GainOne) begin
                            gain_q   <= GainUnity;
                            state_q  <= StRun;
                            fading_q <= 1'b0;
                        end else begin
                            gain_q <= gain_q + GainOne;
                        end
                    end else begin
                        tick_q <= tick_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    // Stage 1: raw sums, selected by the mode actually being played.
    logic [MIX_W-1:0] l10_q;
    logic [MIX_W-1:0] r10_q;
    logic             s1_vld_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            l10_q    <= '0;
            r10_q    <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= ce;
            if (ce) begin
                l10_q <= mix_sum(mode_q, covox_data[7:0], psg_a, psg_b, spk, psg_active);
                r10_q <= mix_sum(mode_q, covox_data[15:8], psg_c, psg_b, spk, psg_active);
            end
        end
    end

    // Stage 2: scale by gain at full width, then truncate.
    logic [OUT_W-1:0]  mix_l;
    logic [OUT_W-1:0]  mix_r;
    logic [PROD_W-1:0] prod_l;
    logic [PROD_W-1:0] prod_r;
    logic [OUT_W-1:0]  gained_l;
    logic [OUT_W-1:0]  gained_r;
    logic [OUT_W-1:0]  out_l;
    logic [OUT_W-1:0]  out_r;

    assign mix_l    = {l10_q, {(OUT_W - MIX_W){1'b0}}};
    assign mix_r    = {r10_q, {(OUT_W - MIX_W){1'b0}}};
    assign prod_l   = PROD_W'(mix_l) * PROD_W'(gain_q);
    assign prod_r   = PROD_W'(mix_r) * PROD_W'(gain_q);
    assign gained_l = OUT_W'(prod_l >> RAMP_SHIFT);
    assign gained_r = OUT_W'(prod_r >> RAMP_SHIFT);

`ifdef AUDIO_MIX_DCBLOCK_EN
    logic dc_clr;
    assign dc_clr = ce && (state_q == StSwitch);

    audio_dcblock u_dcblock_l (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (dc_clr),
        .en      (s1_vld_q),
        .din     (gained_l),
        .dout    (out_l)
    );

    audio_dcblock u_dcblock_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (dc_clr),
        .en      (s1_vld_q),
        .din     (gained_r),
        .dout    (out_r)
    );
`else
    assign out_l = gained_l;
    assign out_r = gained_r;
`endif

    logic [OUT_W-1:0] left_q;
    logic [OUT_W-1:0] right_q;
    logic             valid_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                left_q  <= out_l;
                right_q <= out_r;
            end
        end
    end

    assign left   = left_q;
    assign right  = right_q;
    assign valid  = valid_q;
    assign mode   = mode_q;
    assign fading = fading_q;

endmodule

// File: doc/audio_mix.md
Name: audio_mix

Overview:
- Sample-rate audio mixing stage between the sound sources and the sigma-delta DACs / I2S.
- Sound sources: PSG channels, speaker bits from the system register, and Covox port bytes.
- Mixes according to the selected sound mode and registers one 16-bit stereo sample per sample tick.
- Fades out and back in on every PSG/Covox mode change so mode switches do not click.

Parameters:
- RAMP_SHIFT, 4: gain resolution; gain runs 0..2^RAMP_SHIFT, and 2^RAMP_SHIFT means unity.
- RAMP_DIV, 64: number of sample ticks per gain step during a fade (legal range 1..255).

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- ce, in, 1: sample tick, one clk_sys cycle wide (driven from ce_psg).
- covox_enable, in, 1: requested mode; 1 = Covox, 0 = PSG.
- covox_data, in, 16: Covox port latch; [7:0] is left, [15:8] is right.
- spk, in, 3: speaker bits.
- psg_a, in, 8: PSG channel A, unsigned.
- psg_b, in, 8: PSG channel B, unsigned.
- psg_c, in, 8: PSG channel C, unsigned.
- psg_active, in, 1: PSG has at least one active channel.
- left, out, 16: left sample, unsigned offset-binary.
- right, out, 16: right sample, unsigned offset-binary.
- valid, out, 1: one-cycle pulse when left/right update.
- mode, out, 1: mode currently being played.
- fading, out, 1: high while a fade is in progress.

Behaviour:
- Reset: left=0, right=0, valid=0, fading=0, gain=2^RAMP_SHIFT, mode=covox_enable, state=RUN, tick counter=0.
- Stage 1, on ce:
  - Registers the 10-bit raw sums L10/R10, selected by the internal `mode` (not covox_enable).
  - Covox: L10 = {0,covox_data[7:0],0} + {00,spk,00000}; R10 is the same using [15:8].
  - PSG, psg_active=1: L10 = {0,a,0} + {00,b} + {00,spk,00000}; R10 = {0,c,0} + {00,b} + {00,spk,00000}.
  - PSG, psg_active=0: L10 = R10 = {spk,7'b0}.
  - Sums cannot exceed 10 bits; no saturation is needed.
- Stage 2, one cycle after stage 1:
  - mix16 = {L10,6'b0}.
  - out = (mix16 * gain) >> RAMP_SHIFT, computed at full width (16+RAMP_SHIFT+1 bits) and then truncated.
  - Unity gain gives exactly mix16.
  - left/right are registered and valid pulses in the same cycle.
  - Latency: ce to valid is 2 cycles. Outputs hold between pulses.
- FSM (advances only on ce; tick counter counts ce up to RAMP_DIV, then steps gain and clears):
  - RUN: if covox_enable != mode, go to FADE_OUT and set fading=1.
  - FADE_OUT: gain decrements once per RAMP_DIV ticks. When gain reaches 0, go to SWITCH.
  - SWITCH: lasts one ce. Sets mode=covox_enable, sampled at this instant. Then go to FADE_IN. If covox_enable was toggled back before SWITCH, mode is unchanged and the block still fades in.
  - FADE_IN: gain increments per RAMP_DIV ticks. At unity go to RUN, fading=0. If covox_enable != mode during FADE_IN, go to FADE_OUT from the current gain with no jump.
- Gain never wraps: it is clamped to 0..2^RAMP_SHIFT.
- Reset mid-fade: immediate return to reset values, with no fade.
- ce and reset in the same cycle: reset wins.
- Inputs change without ce: no effect.

Optional Feature:
- Macro: AUDIO_MIX_DCBLOCK_EN.
- Defined: stage 2 adds a first-order DC blocker per channel.
  - Signed 18-bit: x = out - 16'h8000; y = x - x_prev + y_prev - (y_prev >>> 8).
  - Output = sat16(y) + 16'h8000.
  - State is updated on stage-2 cycles only and cleared by reset and at SWITCH.
  - Latency is unchanged (2 cycles).
- Undefined: outputs are the raw gained mix, as above.

Decomposition:
- Package audio_mix_pkg:
  - State enum {RUN, FADE_OUT, SWITCH, FADE_IN}.
  - Constants MIX_W=10 and OUT_W=16.
  - Function for the 10-bit mix formula.
- One sub-module, audio_dcblock (single channel, instantiated twice), present only under AUDIO_MIX_DCBLOCK_EN.

Test Plan:
- PSG mode, psg_active=1, a=8'h80, b=8'h40, c=8'h20, spk=0, single ce -> 2 cycles later valid=1, left=16'h5000, right=16'h2000.
- PSG mode, psg_active=0, spk=3'b111 -> left=right=16'hE000; with spk=0 -> both 16'h0000.
- Reset with covox_enable=1, covox_data=16'h80FF, spk=0 -> left=16'h7F80, right=16'h4000, fading=0.
- RAMP_DIV=1, RAMP_SHIFT=4, steady PSG 16'h5000, toggle covox_enable:
  - -> fading rises.
  - -> left steps down by 16'h0500 per ce to 0.
  - -> mode flips at SWITCH.
  - -> fades back in to the Covox value over 16 ce.
  - -> fading falls.
- Toggle covox_enable and toggle it back during FADE_OUT -> full fade to 0, mode unchanged, fade back in. Toggle during FADE_IN at gain=8 -> gain decreases from 8 with no jump.
- Assert reset at gain=5 during FADE_OUT -> next cycle gain=16, state RUN, left=right=0, valid=0, mode=covox_enable.
